// File: rtl/sr_field_generator_if.sv
// Settings and sample bus of the phi^n field generator.
// Drive settings flow in; the packed field and noise lanes plus the burst envelope flow out.
interface sr_field_generator_if #(
  parameter int WIDTH         = 18,
  parameter int NUM_HARMONICS = 5
);
  logic                           clk_en;
  logic signed [WIDTH-1:0]        field_amp;
  logic signed [WIDTH-1:0]        burst_boost;
  logic                           burst_req;
  logic [13:0]                    ramp_step;
  logic [15:0]                    hold_len;
  logic [2:0]                     noise_shift;
  logic [NUM_HARMONICS*WIDTH-1:0] sr_field_packed;
  logic [NUM_HARMONICS*WIDTH-1:0] noise_packed;
  logic [WIDTH-1:0]               envelope;
  logic                           burst_active;

  modport master (
    output clk_en, field_amp, burst_boost, burst_req, ramp_step, hold_len, noise_shift,
    input  sr_field_packed, noise_packed, envelope, burst_active
  );

  modport slave (
    input  clk_en, field_amp, burst_boost, burst_req, ramp_step, hold_len, noise_shift,
    output sr_field_packed, noise_packed, envelope, burst_active
  );
endinterface

// File: rtl/sr_field_generator.sv
// Five phi^n-scaled rotor field drives with a burst-envelope gain, plus five LFSR noise streams.
// All state advances on clk_en ticks; only the burst request latch samples every clock.
module sr_field_generator #(
  parameter int WIDTH         = 18,
  parameter int FRAC          = 14,
  parameter int NUM_HARMONICS = 5
) (
  input logic                 clk,
  input logic                 rst,
  sr_field_generator_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam logic [15:0] OMEGA [NUM_HARMONICS] = '{16'd193, 16'd312, 16'd504, 16'd817, 16'd1321};
  localparam logic [31:0] SEED [NUM_HARMONICS] =
    '{32'hACE1_0001, 32'h1357_9BDF, 32'h2468_ACE0, 32'hDEAD_BEE5, 32'h0F0F_1235};
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic signed [WIDTH-1:0] ONE_W  = {{(WIDTH-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
  localparam logic signed [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic signed [WIDTH-1:0] MAX_W  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [15:0] ENV_FULL = 16'd16384;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ATTACK = 2'd1, ST_HOLD = 2'd2, ST_DECAY = 2'd3} state_t;

  function automatic logic signed [PW-1:0] sext(input logic signed [WIDTH-1:0] v);
    return {{(PW-WIDTH){v[WIDTH-1]}}, v};
  endfunction

  function automatic logic signed [PW-1:0] omega_pw(input int h);
    return {{(PW-16){1'b0}}, OMEGA[h]};
  endfunction

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [PW-1:0] v);
    if (v > sext(MAX_W)) return MAX_W;
    else if (v < sext(MIN_W)) return MIN_W;
    else return v[WIDTH-1:0];
  endfunction

  logic signed [WIDTH-1:0] x_q     [NUM_HARMONICS];
  logic signed [WIDTH-1:0] x_d     [NUM_HARMONICS];
  logic signed [WIDTH-1:0] y_q     [NUM_HARMONICS];
  logic signed [WIDTH-1:0] y_d     [NUM_HARMONICS];
  logic signed [WIDTH-1:0] field_q [NUM_HARMONICS];
  logic signed [WIDTH-1:0] field_d [NUM_HARMONICS];
  logic signed [WIDTH-1:0] noise_q [NUM_HARMONICS];
  logic signed [WIDTH-1:0] noise_d [NUM_HARMONICS];
  logic [31:0]             lfsr_q  [NUM_HARMONICS];
  logic [31:0]             lfsr_d  [NUM_HARMONICS];
  logic signed [WIDTH-1:0] gain_q;
  logic signed [WIDTH-1:0] gain_d;
  logic signed [PW-1:0]    g_s;

  state_t      state_q;
  logic [15:0] envelope_q;
  logic [15:0] hold_cnt_q;
  logic        req_pend_q;
  logic        burst_active_q;
  logic [16:0] env_up_s;
  logic        req_s;

  // Next-tick datapath: gain from the current envelope, field from the current x and gain_q.
  always_comb begin
    g_s = sext(bus.field_amp)
        + ((sext(bus.burst_boost) * $signed({{(PW-16){1'b0}}, envelope_q})) >>> FRAC);
    if (g_s[PW-1]) gain_d = ZERO_W;
    else if (g_s > sext(ONE_W)) gain_d = ONE_W;
    else gain_d = g_s[WIDTH-1:0];
    for (int h = 0; h < NUM_HARMONICS; h++) begin
      // Symplectic Euler: y uses the freshly updated x, which keeps the orbit amplitude bounded.
      x_d[h] = x_q[h] - WIDTH'((omega_pw(h) * sext(y_q[h])) >>> FRAC);
      y_d[h] = y_q[h] + WIDTH'((omega_pw(h) * sext(x_d[h])) >>> FRAC);
      field_d[h] = sat((sext(x_q[h]) * sext(gain_q)) >>> FRAC);
      noise_d[h] = $signed({{(WIDTH-16){lfsr_q[h][15]}}, lfsr_q[h][15:0]}) >>> bus.noise_shift;
      if (lfsr_q[h][0]) lfsr_d[h] = (lfsr_q[h] >> 1'b1) ^ LFSR_MASK;
      else lfsr_d[h] = lfsr_q[h] >> 1'b1;
    end
  end

  // Datapath registers: rotors, LFSRs, gain and the output lanes.
  always_ff @(posedge clk) begin
    if (rst) begin
      gain_q <= ZERO_W;
      for (int h = 0; h < NUM_HARMONICS; h++) begin
        x_q[h]     <= ONE_W;
        y_q[h]     <= ZERO_W;
        field_q[h] <= ZERO_W;
        noise_q[h] <= ZERO_W;
        lfsr_q[h]  <= SEED[h];
      end
    end else if (bus.clk_en) begin
      gain_q <= gain_d;
      for (int h = 0; h < NUM_HARMONICS; h++) begin
        x_q[h]     <= x_d[h];
        y_q[h]     <= y_d[h];
        field_q[h] <= field_d[h];
        noise_q[h] <= noise_d[h];
        lfsr_q[h]  <= lfsr_d[h];
      end
    end
  end

  // Envelope helpers: a same-clock request counts as pending on the tick that consumes it.
  always_comb begin
    env_up_s = {1'b0, envelope_q} + {3'b000, bus.ramp_step};
    req_s    = req_pend_q | bus.burst_req;
  end

  // Burst-envelope FSM and request latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      envelope_q     <= 16'd0;
      hold_cnt_q     <= 16'd0;
      req_pend_q     <= 1'b0;
      burst_active_q <= 1'b0;
    end else if (bus.clk_en) begin
      req_pend_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          envelope_q <= 16'd0;
          if (req_s) begin
            state_q        <= ST_ATTACK;
            burst_active_q <= 1'b1;
          end
        end
        ST_ATTACK: begin
          if (env_up_s >= {1'b0, ENV_FULL}) begin
            envelope_q <= ENV_FULL;
            hold_cnt_q <= bus.hold_len;
            state_q    <= ST_HOLD;
          end else begin
            envelope_q <= env_up_s[15:0];
          end
        end
        ST_HOLD: begin
          if (hold_cnt_q == 16'd0) state_q <= ST_DECAY;
          else hold_cnt_q <= hold_cnt_q - 16'd1;
        end
        ST_DECAY: begin
          // Retrigger wins over reaching zero and restarts the attack from the current level.
          if (req_s) begin
            state_q <= ST_ATTACK;
          end else if ({2'b00, bus.ramp_step} >= envelope_q) begin
            envelope_q     <= 16'd0;
            state_q        <= ST_IDLE;
            burst_active_q <= 1'b0;
          end else begin
            envelope_q <= envelope_q - {2'b00, bus.ramp_step};
          end
        end
        default: begin
          state_q        <= ST_IDLE;
          envelope_q     <= 16'd0;
          burst_active_q <= 1'b0;
        end
      endcase
    end else if (bus.burst_req) begin
      req_pend_q <= 1'b1;
    end
  end

  for (genvar h = 0; h < NUM_HARMONICS; h++) begin : g_pack
    assign bus.sr_field_packed[h*WIDTH +: WIDTH] = field_q[h];
    assign bus.noise_packed[h*WIDTH +: WIDTH]    = noise_q[h];
  end

  assign bus.envelope     = {{(WIDTH-16){1'b0}}, envelope_q};
  assign bus.burst_active = burst_active_q;
endmodule
